// File: rtl/uart_pkt_scheduler.sv
// uart_pkt_scheduler
// Shares one UART transmitter between the raw (ch0) and filtered (ch1) ECG
// sample streams. Each channel owns a one-deep holding register; a
// round-robin arbiter picks a full register, and the FSM frames the sample
// as SYNC, {ch,seq}, MSB, LSB and walks the tx_start/tx_busy handshake one
// byte at a time.
// Build option: define UART_PKT_CHECKSUM_EN to append an XOR checksum byte
// (B1^B2^B3), giving 5-byte packets instead of 4.
module uart_pkt_scheduler #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         OVF_W     = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             s0_valid,
  input  logic [15:0]      s0_data,
  input  logic             s1_valid,
  input  logic [15:0]      s1_data,
  output logic             s0_ready,
  output logic             s1_ready,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  input  logic             tx_busy,
  output logic             pkt_busy,
  output logic [OVF_W-1:0] ovf0_cnt,
  output logic [OVF_W-1:0] ovf1_cnt
);

`ifdef UART_PKT_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t      state;
  logic [15:0] hold0, hold1;
  logic        full0, full1;
  logic [6:0]  seq;
  logic        rr_ptr;
  logic        pkt_ch;
  logic [6:0]  pkt_seq;
  logic [15:0] pkt_sample;
  logic [2:0]  byte_idx;
  logic        pkt_done;
  logic        rel0, rel1;
  logic        grant_ch;

  // Byte selector for the packet currently being framed
  function automatic logic [7:0] pkt_byte(input logic [2:0] idx, input logic ch,
                                          input logic [6:0] sq, input logic [15:0] smp);
    logic [7:0] b;
    case (idx)
      3'd0:    b = SYNC_BYTE;
      3'd1:    b = {ch, sq};
      3'd2:    b = smp[15:8];
      3'd3:    b = smp[7:0];
`ifdef UART_PKT_CHECKSUM_EN
      default: b = {ch, sq} ^ smp[15:8] ^ smp[7:0];
`else
      default: b = 8'h00;
`endif
    endcase
    return b;
  endfunction

  // The last byte has finished when the transmitter drops busy on LAST_IDX;
  // that is the cycle the granted holding register is handed back.
  assign pkt_done = (state == WAIT_DONE) && !tx_busy && (byte_idx == LAST_IDX);
  assign rel0     = pkt_done && !pkt_ch;
  assign rel1     = pkt_done &&  pkt_ch;

  // On a tie the channel not served last wins; otherwise whichever is full
  assign grant_ch = (full0 && full1) ? rr_ptr : full1;

  assign s0_ready = !full0;
  assign s1_ready = !full1;
  assign pkt_busy = (state != IDLE);

  // ch0 holding register: accepts into an empty or just-released slot, else counts a drop
  always_ff @(posedge Clk) begin
    if (Rst) begin
      hold0    <= 16'h0000;
      full0    <= 1'b0;
      ovf0_cnt <= '0;
    end else if (s0_valid && (!full0 || rel0)) begin
      hold0 <= s0_data;
      full0 <= 1'b1;
    end else begin
      if (rel0)
        full0 <= 1'b0;
      if (s0_valid && full0 && (ovf0_cnt != {OVF_W{1'b1}}))
        ovf0_cnt <= ovf0_cnt + 1'b1;
    end
  end

  // ch1 holding register: same policy as ch0
  always_ff @(posedge Clk) begin
    if (Rst) begin
      hold1    <= 16'h0000;
      full1    <= 1'b0;
      ovf1_cnt <= '0;
    end else if (s1_valid && (!full1 || rel1)) begin
      hold1 <= s1_data;
      full1 <= 1'b1;
    end else begin
      if (rel1)
        full1 <= 1'b0;
      if (s1_valid && full1 && (ovf1_cnt != {OVF_W{1'b1}}))
        ovf1_cnt <= ovf1_cnt + 1'b1;
    end
  end

  // Packet FSM: grant, then one start pulse per byte, waiting for busy to rise and fall
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      seq        <= 7'd0;
      rr_ptr     <= 1'b0;
      pkt_ch     <= 1'b0;
      pkt_seq    <= 7'd0;
      pkt_sample <= 16'h0000;
      byte_idx   <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          tx_start <= 1'b0;
          if ((full0 || full1) && !tx_busy) begin
            pkt_ch     <= grant_ch;
            pkt_sample <= grant_ch ? hold1 : hold0;
            pkt_seq    <= seq;
            byte_idx   <= 3'd0;
            tx_data    <= SYNC_BYTE;
            tx_start   <= 1'b1;
            state      <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          tx_start <= 1'b0;
          if (tx_busy)
            state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          tx_start <= 1'b0;
          if (!tx_busy) begin
            if (byte_idx == LAST_IDX) begin
              seq    <= seq + 7'd1;
              rr_ptr <= ~pkt_ch;
              state  <= IDLE;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              tx_data  <= pkt_byte(byte_idx + 3'd1, pkt_ch, pkt_seq, pkt_sample);
              tx_start <= 1'b1;
              state    <= WAIT_BUSY;
            end
          end
        end
        default: begin
          tx_start <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
